// File: rtl/rrp_arbiter_n_if.sv
// Source-side and sink-side signals of the round-robin stream arbiter, bundled with
// modports for the arbiter (slave) and the sources/sink driving it (master).
interface rrp_arbiter_n_if #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned CH_BITS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0]            ENABLE;
  logic [WIDTH-1:0]            WRITE_REQ;
  logic [WIDTH-1:0]            HOLD_REQ;
  logic [WIDTH*DATA_WIDTH-1:0] DATA_IN;
  logic [WIDTH-1:0]            READ_GRANT;
  logic                        READY_OUT;
  logic                        WRITE_OUT;
  logic [DATA_WIDTH-1:0]       DATA_OUT;
  logic [CH_BITS-1:0]          GRANT_ID;
  logic                        BUSY;

  modport master (
    output ENABLE, WRITE_REQ, HOLD_REQ, DATA_IN, READY_OUT,
    input  READ_GRANT, WRITE_OUT, DATA_OUT, GRANT_ID, BUSY
  );

  modport slave (
    input  ENABLE, WRITE_REQ, HOLD_REQ, DATA_IN, READY_OUT,
    output READ_GRANT, WRITE_OUT, DATA_OUT, GRANT_ID, BUSY
  );
endinterface

// File: rtl/rrp_arbiter_n.sv
// N-channel burst round-robin arbiter merging FWFT sources into one registered stream.
// Optional ARB_CHANNEL_TAG_EN: overwrite the top CH_BITS of each loaded word with the source id.
module rrp_arbiter_n #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 16
) (
  input logic           BUS_CLK,
  input logic           BUS_RST_B,
  rrp_arbiter_n_if.slave bus
);
  localparam int unsigned CH_BITS = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned BC_BITS = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam int unsigned SUM_BITS = CH_BITS + 1;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                state_q;
  logic [CH_BITS-1:0]    ptr_q;
  logic [CH_BITS-1:0]    cur_q;
  logic [BC_BITS-1:0]    burst_cnt_q;
  logic                  write_out_q;
  logic [DATA_WIDTH-1:0] data_out_q;

  logic [WIDTH-1:0]      elig;
  logic [WIDTH-1:0]      hold_elig;
  logic [2*WIDTH-1:0]    elig_dbl;
  logic [WIDTH-1:0]      elig_rot;
  logic                  out_free;

  assign elig      = bus.ENABLE & bus.WRITE_REQ;
  assign hold_elig = elig & bus.HOLD_REQ;
  assign out_free  = ~write_out_q | bus.READY_OUT;
  // Rotate so that bit 0 of elig_rot corresponds to channel ptr_q.
  assign elig_dbl  = {elig, elig};
  assign elig_rot  = elig_dbl[ptr_q +: WIDTH];

  // Arbitration: lowest holding channel first, otherwise first eligible at/after ptr.
  logic                win_valid;
  logic [CH_BITS-1:0]  win_id;
  logic [CH_BITS-1:0]  hold_id;
  logic [CH_BITS-1:0]  rr_id;
  logic [SUM_BITS-1:0] rr_sum;

  always_comb begin
    hold_id = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (hold_elig[i]) hold_id = CH_BITS'(i);
    end
  end

  always_comb begin
    rr_sum = '0;
    rr_id  = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      if (elig_rot[k]) begin
        rr_sum = {1'b0, ptr_q} + SUM_BITS'(k);
        if (rr_sum >= SUM_BITS'(WIDTH)) rr_sum = rr_sum - SUM_BITS'(WIDTH);
        rr_id = rr_sum[CH_BITS-1:0];
      end
    end
  end

  always_comb begin
    win_valid = |elig;
    win_id    = (|hold_elig) ? hold_id : rr_id;
  end

  // Current-channel view while a grant is held.
  logic cur_en;
  logic cur_req;
  logic cur_hold;
  logic grant_v;

  assign cur_en   = bus.ENABLE[cur_q];
  assign cur_req  = bus.WRITE_REQ[cur_q];
  assign cur_hold = bus.HOLD_REQ[cur_q];
  assign grant_v  = (state_q == StSend) & cur_en & cur_req & out_free;

  logic [WIDTH-1:0] read_grant;

  always_comb begin
    read_grant = '0;
    if (grant_v) read_grant[cur_q] = 1'b1;
  end

  // Word selection for the output register.
  logic [DATA_WIDTH-1:0] sel_data;
  logic [DATA_WIDTH-1:0] load_word;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (cur_q == CH_BITS'(i)) sel_data = bus.DATA_IN[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef ARB_CHANNEL_TAG_EN
  always_comb begin
    load_word = sel_data;
    load_word[DATA_WIDTH-1 -: CH_BITS] = cur_q;
  end
`else
  assign load_word = sel_data;
`endif

  // Burst accounting and exit decision.
  logic                 burst_hit;
  logic [BC_BITS-1:0]   burst_inc;
  logic                 exit_send;
  logic [CH_BITS-1:0]   next_ptr;

  // Counter saturates so a long held grant can never wrap back under the limit.
  assign burst_inc = (burst_cnt_q == '1) ? burst_cnt_q : burst_cnt_q + BC_BITS'(1);
  assign burst_hit = (MAX_BURST != 0) && ((32'(burst_cnt_q) + 32'd1) >= MAX_BURST);
  assign exit_send = ~cur_en
                   | (~cur_hold & ~cur_req)
                   | (~cur_hold & grant_v & burst_hit);
  assign next_ptr  = (cur_q == CH_BITS'(WIDTH - 1)) ? '0 : cur_q + CH_BITS'(1);

  always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
    if (!BUS_RST_B) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      cur_q       <= '0;
      burst_cnt_q <= '0;
      write_out_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      // A load and a downstream accept in the same cycle keep WRITE_OUT high.
      if (grant_v) begin
        data_out_q  <= load_word;
        write_out_q <= 1'b1;
      end else if (bus.READY_OUT) begin
        write_out_q <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (win_valid) begin
            cur_q       <= win_id;
            burst_cnt_q <= '0;
            state_q     <= StSend;
          end
        end
        StSend: begin
          if (grant_v) burst_cnt_q <= burst_inc;
          if (exit_send) begin
            state_q <= StIdle;
            ptr_q   <= next_ptr;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.READ_GRANT = read_grant;
  assign bus.WRITE_OUT  = write_out_q;
  assign bus.DATA_OUT   = data_out_q;
  assign bus.GRANT_ID   = cur_q;
  assign bus.BUSY       = (state_q == StSend);

`ifndef SYNTHESIS
  a_grant_onehot: assert property (@(posedge BUS_CLK) disable iff (!BUS_RST_B)
    $onehot0(bus.READ_GRANT));
  a_grant_needs_req: assert property (@(posedge BUS_CLK) disable iff (!BUS_RST_B)
    (bus.READ_GRANT & ~bus.WRITE_REQ) == '0);
`endif

endmodule

// File: tb/tb_rrp_arbiter_n.sv
// Directed + randomized bench for rrp_arbiter_n; sources are modelled as FWFT queues and the
// expected output order is computed from the burst round-robin rules.
module tb_rrp_arbiter_n;
  localparam int unsigned WIDTH     = 4;
  localparam int unsigned DW        = 32;
  localparam int unsigned MAX_BURST = 16;
  localparam int          DEPTH     = 256;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  rrp_arbiter_n_if #(.WIDTH(WIDTH), .DATA_WIDTH(DW)) bus ();

  rrp_arbiter_n #(.WIDTH(WIDTH), .DATA_WIDTH(DW), .MAX_BURST(MAX_BURST)) dut (
    .BUS_CLK  (clk),
    .BUS_RST_B(rst_b),
    .bus      (bus)
  );

  int errors = 0;
  int checks = 0;
  int grants = 0;

  logic [DW-1:0]    mem [WIDTH][DEPTH];
  int               head [WIDTH];
  int               tail [WIDTH];
  logic [WIDTH-1:0] en;
  logic [WIDTH-1:0] hold;
  bit               rnd_ready;
  logic [DW-1:0]    rx [$];
  logic [DW-1:0]    exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] tag_of(input int ch, input logic [DW-1:0] w);
    logic [DW-1:0] r;
    r = w;
`ifdef ARB_CHANNEL_TAG_EN
    r[DW-1 -: 2] = 2'(ch);
`endif
    return r;
  endfunction

  function automatic logic [DW-1:0] mk(input int ch, input int tid);
    logic [DW-1:0] w;
    w = $urandom;
    w[31:30] = 2'(ch);
    w[29:24] = 6'(tid);
    return w;
  endfunction

  task automatic push_word(input int ch, input logic [DW-1:0] w);
    mem[ch][tail[ch]] = w;
    tail[ch]++;
  endtask

  task automatic drive();
    bus.ENABLE    = en;
    bus.HOLD_REQ  = hold;
    bus.READY_OUT = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      bus.WRITE_REQ[i] = (head[i] != tail[i]);
      bus.DATA_IN[i*DW +: DW] = (head[i] != tail[i]) ? mem[i][head[i]] : '0;
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step();
    logic [WIDTH-1:0] g;
    logic             acc;
    logic [DW-1:0]    d;
    drive();
    #1;
    g   = bus.READ_GRANT;
    acc = bus.WRITE_OUT && bus.READY_OUT;
    d   = bus.DATA_OUT;
    if (g != '0)
      check("grant_legal", 64'(($countones(g) == 1) && ((g & ~bus.WRITE_REQ) == '0)), 64'd1);
    if (bus.WRITE_OUT && !bus.READY_OUT) check("stall_no_grant", 64'(g), 64'd0);
    @(posedge clk);
    for (int i = 0; i < WIDTH; i++) begin
      if (g[i] && head[i] != tail[i]) begin
        head[i]++;
        grants++;
      end
    end
    if (acc) rx.push_back(d);
    @(negedge clk);
  endtask

  task automatic run_until(input int n, input int budget);
    for (int c = 0; c < budget && rx.size() < n; c++) step();
  endtask

  task automatic clear_src();
    for (int i = 0; i < WIDTH; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    rx.delete();
    exp_q.delete();
    grants = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_b     = 1'b0;
    en        = '1;
    hold      = '0;
    rnd_ready = 1'b0;
    clear_src();
    drive();
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  // Burst round-robin order from a fresh reset, no holds, all sources preloaded.
  task automatic model_rr();
    int pos [WIDTH];
    int left;
    int p;
    int n;
    int ch;
    p = 0;
    left = 0;
    for (int i = 0; i < WIDTH; i++) begin
      pos[i] = head[i];
      left += tail[i] - head[i];
    end
    while (left > 0) begin
      ch = -1;
      for (int k = 0; k < WIDTH; k++) begin
        if (ch < 0 && pos[(p + k) % WIDTH] < tail[(p + k) % WIDTH]) ch = (p + k) % WIDTH;
      end
      n = tail[ch] - pos[ch];
      if (MAX_BURST != 0 && n > int'(MAX_BURST)) n = int'(MAX_BURST);
      for (int j = 0; j < n; j++) exp_q.push_back(tag_of(ch, mem[ch][pos[ch] + j]));
      pos[ch] += n;
      left -= n;
      p = (ch + 1) % WIDTH;
    end
  endtask

  task automatic compare(input string tag);
    check({tag, "_count"}, 64'(rx.size()), 64'(exp_q.size()));
    for (int i = 0; i < rx.size() && i < exp_q.size(); i++)
      check({tag, "_word"}, 64'(rx[i]), 64'(exp_q[i]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            exp_run [6] = '{16, 16, 16, 16, 8, 8};
    int            runs [$];
    int            lens [WIDTH];
    int            h1;
    logic [DW-1:0] w0a;
    logic [DW-1:0] w0b;
    logic [DW-1:0] exp6;

    // Reset state, with requests already pending.
    rst_b     = 1'b0;
    en        = '1;
    hold      = '0;
    rnd_ready = 1'b0;
    clear_src();
    for (int c = 0; c < WIDTH; c++)
      for (int j = 0; j < 3; j++) push_word(c, mk(c, 1));
    drive();
    @(negedge clk);
    #1;
    check("rst_write_out", 64'(bus.WRITE_OUT), 64'd0);
    check("rst_data_out", 64'(bus.DATA_OUT), 64'd0);
    check("rst_grant_id", 64'(bus.GRANT_ID), 64'd0);
    check("rst_busy", 64'(bus.BUSY), 64'd0);
    check("rst_read_grant", 64'(bus.READ_GRANT), 64'd0);
    @(negedge clk);
    rst_b = 1'b1;

    // 1: three words per channel, strict rotation.
    model_rr();
    run_until(12, 300);
    compare("t1");
    check("t1_grants", 64'(grants), 64'd12);

    // 2: two long streams split into bursts of at most MAX_BURST.
    do_reset();
    for (int j = 0; j < 40; j++) begin
      push_word(1, mk(1, 2));
      push_word(2, mk(2, 2));
    end
    model_rr();
    run_until(80, 600);
    compare("t2");
    for (int i = 0; i < rx.size(); i++) begin
      if (i == 0 || rx[i][31:30] != rx[i-1][31:30]) runs.push_back(1);
      else runs[runs.size()-1]++;
    end
    check("t2_bursts", 64'(runs.size()), 64'd6);
    for (int i = 0; i < runs.size() && i < 6; i++) check("t2_burst_len", 64'(runs[i]), 64'(exp_run[i]));

    // 3: hold request jumps the rotation and keeps the grant while empty.
    do_reset();
    for (int j = 0; j < 20; j++) push_word(2, mk(2, 3));
    for (int j = 0; j < 5; j++) push_word(3, mk(3, 3));
    w0a = mk(0, 3);
    w0b = mk(0, 3);
    for (int j = 0; j < 16; j++) exp_q.push_back(tag_of(2, mem[2][j]));
    exp_q.push_back(tag_of(0, w0a));
    exp_q.push_back(tag_of(0, w0b));
    for (int j = 16; j < 20; j++) exp_q.push_back(tag_of(2, mem[2][j]));
    for (int j = 0; j < 5; j++) exp_q.push_back(tag_of(3, mem[3][j]));
    for (int c = 0; c < 20 && !(bus.BUSY && bus.GRANT_ID == 2); c++) step();
    check("t3_ch2_first", 64'(bus.GRANT_ID), 64'd2);
    push_word(0, w0a);
    push_word(0, w0b);
    hold[0] = 1'b1;
    run_until(18, 200);
    for (int c = 0; c < 4; c++) step();
    check("t3_hold_busy", 64'(bus.BUSY), 64'd1);
    check("t3_hold_id", 64'(bus.GRANT_ID), 64'd0);
    check("t3_hold_rx", 64'(rx.size()), 64'd18);
    hold[0] = 1'b0;
    run_until(27, 300);
    compare("t3");

    // 4: random downstream back-pressure over 200 words from four channels.
    do_reset();
    rnd_ready = 1'b1;
    lens[WIDTH-1] = 200;
    for (int c = 0; c < WIDTH - 1; c++) begin
      lens[c] = $urandom_range(40, 60);
      lens[WIDTH-1] -= lens[c];
    end
    for (int c = 0; c < WIDTH; c++)
      for (int j = 0; j < lens[c]; j++) push_word(c, mk(c, 4));
    model_rr();
    run_until(200, 5000);
    compare("t4");
    check("t4_grant_count", 64'(grants), 64'(rx.size()));
    rnd_ready = 1'b0;

    // 5a: disabling the held channel ends the grant at once.
    do_reset();
    for (int j = 0; j < 10; j++) push_word(1, mk(1, 5));
    hold[1] = 1'b1;
    run_until(3, 100);
    check("t5_busy_before", 64'(bus.BUSY), 64'd1);
    en[1] = 1'b0;
    drive();
    #1;
    check("t5_no_grant_on_disable", 64'(bus.READ_GRANT), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("t5_busy_after", 64'(bus.BUSY), 64'd0);
    h1 = head[1];
    for (int c = 0; c < 10; c++) step();
    check("t5_ch1_no_more", 64'(head[1]), 64'(h1));
    check("t5_idle", 64'(bus.BUSY), 64'd0);

    // 5b: asynchronous reset mid-burst.
    do_reset();
    for (int j = 0; j < 10; j++) push_word(2, mk(2, 5));
    run_until(3, 100);
    check("t5_id_before_rst", 64'(bus.GRANT_ID), 64'd2);
    #2;
    rst_b = 1'b0;
    #1;
    check("t5_rst_write_out", 64'(bus.WRITE_OUT), 64'd0);
    check("t5_rst_grant_id", 64'(bus.GRANT_ID), 64'd0);
    check("t5_rst_busy", 64'(bus.BUSY), 64'd0);
    check("t5_rst_data_out", 64'(bus.DATA_OUT), 64'd0);
    @(negedge clk);
    rst_b = 1'b1;

    // 6: channel tag on the output word.
    do_reset();
    push_word(3, 32'h0000_00AA);
`ifdef ARB_CHANNEL_TAG_EN
    exp6 = 32'hC000_00AA;
`else
    exp6 = 32'h0000_00AA;
`endif
    run_until(1, 50);
    check("t6_rx", 64'(rx.size()), 64'd1);
    check("t6_word", (rx.size() > 0) ? 64'(rx[0]) : 64'hx, 64'(exp6));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
